// File: rtl/armleocpu_mem_responder_if.sv
// Avalon-MM burst bus between armleocpu_cache's m_* port and the on-chip memory responder.
interface armleocpu_mem_responder_if;
    logic [33:0] m_address;
    logic [3:0]  m_burstcount;
    logic        m_waitrequest;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;

    modport master (
        output m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        input  m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/armleocpu_mem_responder.sv
// Avalon-MM burst responder backed by a 1w1r word RAM, with fixed read latency and
// wrap-around bursts; flags protocol/decode violations with a one-cycle pulse.
module armleocpu_mem_responder #(
    parameter int          MEM_W        = 12,
    parameter logic [33:0] BASE_ADDR    = 34'h0,
    parameter int          READ_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    armleocpu_mem_responder_if.slave    bus,
    output logic                        protocol_error
);
    localparam int         DEPTH     = 2 ** MEM_W;
    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 2);

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DATA, WRITE} state_t;

    state_t             state, state_nxt;
    logic [MEM_W-1:0]   word_ptr, word_ptr_nxt;
    logic [4:0]         left, left_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic               bad, bad_nxt;

    logic               mem_we;
    logic [MEM_W-1:0]   mem_waddr;
    logic               rd_beat;
    logic               perr_nxt;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rdata_q;
    logic               valid_q;
    logic               perr_q;

    logic               cmd_bad;
    logic [MEM_W-1:0]   cmd_idx;
    logic [4:0]         cmd_beats;

    assign cmd_bad   = (bus.m_address[33:MEM_W+2] != BASE_ADDR[33:MEM_W+2])
                    || (bus.m_address[1:0] != 2'b00);
    assign cmd_idx   = bus.m_address[MEM_W+1:2];
    assign cmd_beats = (bus.m_burstcount == 4'd0) ? 5'd16 : {1'b0, bus.m_burstcount};

    assign bus.m_waitrequest   = !rst_n || (state == READ_WAIT) || (state == READ_DATA);
    assign bus.m_readdata      = rdata_q;
    assign bus.m_readdatavalid = valid_q;
    assign protocol_error      = perr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_ptr <= '0;
            left     <= '0;
            wait_cnt <= '0;
            bad      <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_ptr <= word_ptr_nxt;
            left     <= left_nxt;
            wait_cnt <= wait_cnt_nxt;
            bad      <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_ptr_nxt = word_ptr;
        left_nxt     = left;
        wait_cnt_nxt = wait_cnt;
        bad_nxt      = bad;
        mem_we       = 1'b0;
        mem_waddr    = word_ptr;
        rd_beat      = 1'b0;
        perr_nxt     = 1'b0;
        case (state)
            IDLE: begin
                // A write wins over a simultaneous read; the read is dropped and flagged.
                if (bus.m_write) begin
                    perr_nxt     = bus.m_read || cmd_bad;
                    mem_we       = !cmd_bad;
                    mem_waddr    = cmd_idx;
                    word_ptr_nxt = cmd_idx + MEM_W'(1);
                    left_nxt     = cmd_beats - 5'd1;
                    bad_nxt      = cmd_bad;
                    if (cmd_beats != 5'd1)
                        state_nxt = WRITE;
                end else if (bus.m_read) begin
                    perr_nxt     = cmd_bad;
                    word_ptr_nxt = cmd_idx;
                    left_nxt     = cmd_beats;
                    bad_nxt      = cmd_bad;
                    wait_cnt_nxt = '0;
                    state_nxt    = (READ_LATENCY == 1) ? READ_DATA : READ_WAIT;
                end
            end
            READ_WAIT: begin
                wait_cnt_nxt = wait_cnt + 4'd1;
                if (wait_cnt == WAIT_LAST)
                    state_nxt = READ_DATA;
            end
            READ_DATA: begin
                rd_beat      = 1'b1;
                word_ptr_nxt = word_ptr + MEM_W'(1);
                left_nxt     = left - 5'd1;
                if (left == 5'd1)
                    state_nxt = IDLE;
            end
            WRITE: begin
                perr_nxt = bus.m_read;
                if (bus.m_write) begin
                    mem_we       = !bad;
                    mem_waddr    = word_ptr;
                    word_ptr_nxt = word_ptr + MEM_W'(1);
                    left_nxt     = left - 5'd1;
                    if (left == 5'd1)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM is deliberately left out of reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.m_byteenable[b])
                    mem[mem_waddr][8*b +: 8] <= bus.m_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= rd_beat;
            perr_q  <= perr_nxt;
            if (rd_beat)
                rdata_q <= bad ? 32'h0 : mem[word_ptr];
        end
    end
endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// Self-checking bench for armleocpu_mem_responder: table of bus operations, a reference
// memory model feeding a read-data scoreboard, and hand sequences for reset and protocol corners.
module tb_armleocpu_mem_responder;
    localparam int MEM_W = 12;
    localparam int N     = 1 << MEM_W;
    localparam int LAT   = 2;

    typedef struct {
        bit          isWrite;
        logic [33:0] addr;
        logic [3:0]  burst;
        logic [31:0] data;
        logic [3:0]  be;
        logic [15:0] gaps;
        int          expPerr;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic perr;

    int errors = 0;
    int checks = 0;
    int perrCount = 0;
    bit sbEnable = 1'b1;
    logic [31:0] expQ[$];
    logic [31:0] model [N];
    vec_t vecs[$];

    armleocpu_mem_responder_if bus();

    armleocpu_mem_responder #(
        .MEM_W(MEM_W),
        .BASE_ADDR(34'h0),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .protocol_error(perr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: every valid beat must match the oldest expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (perr === 1'b1)
            perrCount++;
        if (sbEnable && bus.m_readdatavalid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("read_beat", bus.m_readdata, e);
            end
        end
    end

    function automatic bit isGood(input logic [33:0] addr);
        return ((addr >> (MEM_W + 2)) == 34'd0) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic idleBus();
        bus.m_read = 1'b0;
        bus.m_write = 1'b0;
        bus.m_address = '0;
        bus.m_burstcount = 4'd1;
        bus.m_writedata = '0;
        bus.m_byteenable = 4'hF;
    endtask

    // Holds the currently driven command/beat until the responder accepts it.
    task automatic sendBeat(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (bus.m_waitrequest !== 1'b0) begin
            n++;
            if (n > 100) begin
                checkOutput("waitrequest_timeout", 32'd1, 32'd0);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [33:0] addr, input logic [3:0] burst, input logic [31:0] d0,
                           input logic [3:0] be, input logic [15:0] gaps);
        int beats = (burst == 4'd0) ? 16 : int'(burst);
        bit good = isGood(addr);
        int idx = int'(addr[MEM_W+1:2]);
        bit ok;
        for (int k = 0; k < beats; k++) begin
            if (gaps[k]) begin
                bus.m_write = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.m_write = 1'b1;
            bus.m_address = addr;
            bus.m_burstcount = burst;
            bus.m_writedata = d0 + 32'(k);
            bus.m_byteenable = be;
            sendBeat(ok);
            if (!ok) break;
            if (good)
                model[(idx + k) % N] = merge(model[(idx + k) % N], d0 + 32'(k), be);
        end
        bus.m_write = 1'b0;
    endtask

    task automatic doRead(input logic [33:0] addr, input logic [3:0] burst);
        int beats = (burst == 4'd0) ? 16 : int'(burst);
        bit good = isGood(addr);
        int idx = int'(addr[MEM_W+1:2]);
        int lat = 0;
        bit ok;
        for (int k = 0; k < beats; k++)
            expQ.push_back(good ? model[(idx + k) % N] : 32'h0);
        bus.m_read = 1'b1;
        bus.m_address = addr;
        bus.m_burstcount = burst;
        sendBeat(ok);
        bus.m_read = 1'b0;
        if (!ok) begin
            expQ.delete();
            return;
        end
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (bus.m_readdatavalid !== 1'b1 && lat < 100);
        checkOutput("read_latency", 32'(lat), 32'(LAT));
        for (int k = 1; k < beats; k++) begin
            @(negedge clk);
            checkOutput("beat_contiguous", 32'(bus.m_readdatavalid), 32'd1);
        end
        @(negedge clk);
        checkOutput("burst_end", 32'(bus.m_readdatavalid), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int p0 = perrCount;
        if (v.isWrite)
            doWrite(v.addr, v.burst, v.data, v.be, v.gaps);
        else
            doRead(v.addr, v.burst);
        repeat (2) @(negedge clk);
        checkOutput({"perr_", v.name}, 32'(perrCount - p0), 32'(v.expPerr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int n;
        bit ok;

        vecs.push_back('{1'b1, 34'h40,   4'd1, 32'hCAFEBABE, 4'hF, 16'h0000, 0, "single_wr"});
        vecs.push_back('{1'b0, 34'h40,   4'd1, 32'h0,        4'hF, 16'h0000, 0, "single_rd"});
        vecs.push_back('{1'b1, 34'h100,  4'd0, 32'h0,        4'hF, 16'h0088, 0, "line_wr"});
        vecs.push_back('{1'b0, 34'h100,  4'd0, 32'h0,        4'hF, 16'h0000, 0, "line_rd"});
        vecs.push_back('{1'b1, 34'h3FFC, 4'd4, 32'hA0,       4'hF, 16'h0000, 0, "wrap_wr"});
        vecs.push_back('{1'b0, 34'h3FFC, 4'd4, 32'h0,        4'hF, 16'h0000, 0, "wrap_rd"});
        vecs.push_back('{1'b1, 34'h200,  4'd1, 32'hFFFFFFFF, 4'hF, 16'h0000, 0, "be_init"});
        vecs.push_back('{1'b1, 34'h200,  4'd1, 32'h12345678, 4'h5, 16'h0000, 0, "be_wr"});
        vecs.push_back('{1'b0, 34'h200,  4'd1, 32'h0,        4'hF, 16'h0000, 0, "be_rd"});
        vecs.push_back('{1'b1, 34'h0,    4'd1, 32'h55AA55AA, 4'hF, 16'h0000, 0, "w0"});
        vecs.push_back('{1'b0, 34'h4000, 4'd2, 32'h0,        4'hF, 16'h0000, 1, "oor_rd"});
        vecs.push_back('{1'b1, 34'h4000, 4'd2, 32'hDEAD0000, 4'hF, 16'h0000, 1, "oor_wr"});
        vecs.push_back('{1'b0, 34'h0,    4'd2, 32'h0,        4'hF, 16'h0000, 0, "oor_unchanged"});
        vecs.push_back('{1'b0, 34'h42,   4'd1, 32'h0,        4'hF, 16'h0000, 1, "misaligned_rd"});
        vecs.push_back('{1'b1, 34'h40,   4'd1, 32'h0,        4'h0, 16'h0000, 0, "be_zero_wr"});
        vecs.push_back('{1'b0, 34'h40,   4'd1, 32'h0,        4'hF, 16'h0000, 0, "be_zero_rd"});

        idleBus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_waitrequest", 32'(bus.m_waitrequest), 32'd1);
        checkOutput("reset_valid", 32'(bus.m_readdatavalid), 32'd0);
        checkOutput("reset_readdata", bus.m_readdata, 32'h0);
        checkOutput("reset_perr", 32'(perr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_waitrequest", 32'(bus.m_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i])
            applyStimulus(vecs[i]);

        $display("[TB] read and write in the same IDLE cycle");
        p0 = perrCount;
        bus.m_read = 1'b1;
        bus.m_write = 1'b1;
        bus.m_address = 34'h80;
        bus.m_burstcount = 4'd1;
        bus.m_writedata = 32'h11112222;
        bus.m_byteenable = 4'hF;
        sendBeat(ok);
        idleBus();
        model[32] = 32'h11112222;
        repeat (6) @(negedge clk);
        checkOutput("perr_rw_collision", 32'(perrCount - p0), 32'd1);
        @(posedge clk);
        #1;
        doRead(34'h80, 4'd1);

        $display("[TB] read asserted during write burst");
        p0 = perrCount;
        bus.m_write = 1'b1;
        bus.m_address = 34'h90;
        bus.m_burstcount = 4'd2;
        bus.m_writedata = 32'h0BADF00D;
        bus.m_byteenable = 4'hF;
        sendBeat(ok);
        bus.m_read = 1'b1;
        bus.m_address = 34'h0;
        bus.m_writedata = 32'h600DCAFE;
        sendBeat(ok);
        idleBus();
        model[36] = 32'h0BADF00D;
        model[37] = 32'h600DCAFE;
        repeat (2) @(negedge clk);
        checkOutput("perr_read_in_write", 32'(perrCount - p0), 32'd1);
        @(posedge clk);
        #1;
        doRead(34'h90, 4'd2);

        $display("[TB] reset in the middle of a read burst");
        sbEnable = 1'b0;
        bus.m_read = 1'b1;
        bus.m_address = 34'h100;
        bus.m_burstcount = 4'd0;
        sendBeat(ok);
        bus.m_read = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.m_readdatavalid !== 1'b1 && n < 100);
        checkOutput("pre_reset_valid", 32'(bus.m_readdatavalid), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("midburst_reset_valid", 32'(bus.m_readdatavalid), 32'd0);
            checkOutput("midburst_reset_waitrequest", 32'(bus.m_waitrequest), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_reset_waitrequest", 32'(bus.m_waitrequest), 32'd0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_readdatavalid === 1'b1) n++;
        end
        checkOutput("no_beats_after_reset", 32'(n), 32'd0);
        sbEnable = 1'b1;
        @(posedge clk);
        #1;
        doRead(34'h40, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
